mandel_pixel_sequencer: RTL and testbench

MANDEL_PIXEL_SEQUENCER -- requirements
Module: mandel_pixel_sequencer

---
 rtl/mandel_pixel_sequencer_pkg.sv | 31 +++
 rtl/mandel_pixel_sequencer_if.sv | 34 +++
 rtl/mandel_iter_counter.sv | 51 +++++
 rtl/mandel_pixel_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mandel_pixel_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mandel_pixel_sequencer_pkg.sv
// Shared types and constants for the Mandelbrot pixel sequencer.
// C values are signed Q4.28 words streamed to the accelerator a byte at a time.
package mandel_pixel_sequencer_pkg;

   localparam int Q_W      = 32;
   localparam int Q_FRAC   = 28;
   localparam int LOAD_LEN = 8;
   localparam int K_W      = $clog2(LOAD_LEN);
   localparam int COORD_W  = 8;

   typedef logic signed [Q_W-1:0] q4_28_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_ITER,
      S_OUT
   } state_e;

   // Byte k of {ci,cr}: cr bytes first, each word LSB first.
   function automatic logic [7:0] c_byte(
      input q4_28_t         cr,
      input q4_28_t         ci,
      input logic [K_W-1:0] k
   );
      logic [2*Q_W-1:0] c;
      c = {ci, cr};
      return c[{k, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/mandel_pixel_sequencer_if.sv
// Accelerator byte bus plus pixel result valid/ready stream.
// master = sequencer side, slave = accelerator/consumer side.
interface mandel_pixel_sequencer_if
   import mandel_pixel_sequencer_pkg::*;
#(
   parameter int MAX_ITER_W = 8
);

   logic [7:0]            acc_data;
   logic                  acc_load_cr;
   logic                  acc_load_ci;
   logic                  acc_start;
   logic                  acc_unbounded;
   logic                  pix_valid;
   logic                  pix_ready;
   logic [MAX_ITER_W-1:0] pix_iter;
   logic [COORD_W-1:0]    pix_x;
   logic [COORD_W-1:0]    pix_y;

   modport master (
      output acc_data, acc_load_cr, acc_load_ci, acc_start,
      input  acc_unbounded,
      output pix_valid, pix_iter, pix_x, pix_y,
      input  pix_ready
   );

   modport slave (
      input  acc_data, acc_load_cr, acc_load_ci, acc_start,
      output acc_unbounded,
      input  pix_valid, pix_iter, pix_x, pix_y,
      output pix_ready
   );

endinterface

// File: rtl/mandel_iter_counter.sv
// Escape-time counter: skips the stale flag on the first ITER cycle,
// then evaluates once per cycle until escape or the iteration limit.
module mandel_iter_counter
   import mandel_pixel_sequencer_pkg::*;
#(
   parameter int MAX_ITER_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   input  logic                  en_i,
   input  logic                  unbounded_i,
   input  logic [MAX_ITER_W-1:0] max_iter_i,
   output logic                  done_o,
   output logic [MAX_ITER_W-1:0] result_o
);

   logic                  skip_q, skip_d;
   logic [MAX_ITER_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skip_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         skip_q <= skip_d;
         cnt_q  <= cnt_d;
      end
   end

   // At the limit cnt_q equals max_iter, so cnt_q is the result either way.
   always_comb begin
      skip_d   = skip_q;
      cnt_d    = cnt_q;
      done_o   = 1'b0;
      result_o = cnt_q;
      if (clr_i) begin
         skip_d = 1'b1;
         cnt_d  = '0;
      end else if (en_i) begin
         if (skip_q) begin
            skip_d = 1'b0;
         end else if (unbounded_i || cnt_q == max_iter_i) begin
            done_o = 1'b1;
         end else begin
            cnt_d = cnt_q + MAX_ITER_W'(1);
         end
      end
   end

endmodule

// File: rtl/mandel_pixel_sequencer.sv
// Walks a frame in raster order, streams each pixel's C to the
// accelerator, waits for the escape count and hands it downstream.
module mandel_pixel_sequencer
   import mandel_pixel_sequencer_pkg::*;
#(
   parameter int MAX_ITER_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_start,
   input  logic [Q_W-1:0]        cr0,
   input  logic [Q_W-1:0]        ci0,
   input  logic [Q_W-1:0]        dcr,
   input  logic [Q_W-1:0]        dci,
   input  logic [COORD_W-1:0]    width,
   input  logic [COORD_W-1:0]    height,
   input  logic [MAX_ITER_W-1:0] max_iter,
   output logic                  busy,
   output logic                  frame_done,
   mandel_pixel_sequencer_if.master bus
);

   state_e                state_q, state_d;
   logic [K_W-1:0]        k_q, k_d;
   logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
   logic [COORD_W-1:0]    w_q, w_d, h_q, h_d;
   logic [MAX_ITER_W-1:0] max_q, max_d, iter_q, iter_d;
   q4_28_t                cr0_q, cr0_d, dcr_q, dcr_d, dci_q, dci_d;
   q4_28_t                cr_q, cr_d, ci_q, ci_d;
   logic                  done_q, done_d;

   logic                  in_load, load_last, xfer;
   logic                  last_x, last_y;
   logic                  cnt_done;
   logic [MAX_ITER_W-1:0] cnt_res;

   mandel_iter_counter #(
      .MAX_ITER_W (MAX_ITER_W)
   ) u_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (load_last),
      .en_i        (state_q == S_ITER),
      .unbounded_i (bus.acc_unbounded),
      .max_iter_i  (max_q),
      .done_o      (cnt_done),
      .result_o    (cnt_res)
   );

   assign in_load   = (state_q == S_LOAD);
   assign load_last = in_load && (k_q == K_W'(LOAD_LEN - 1));
   assign xfer      = bus.pix_valid && bus.pix_ready;
   assign last_x    = (x_q == w_q - COORD_W'(1));
   assign last_y    = (y_q == h_q - COORD_W'(1));

   assign busy            = (state_q != S_IDLE);
   assign frame_done      = done_q;
   assign bus.acc_data    = in_load ? c_byte(cr_q, ci_q, k_q) : 8'h00;
   assign bus.acc_load_cr = in_load && (k_q == K_W'(3));
   assign bus.acc_load_ci = load_last;
   assign bus.acc_start   = load_last;
   assign bus.pix_valid   = (state_q == S_OUT);
   assign bus.pix_iter    = iter_q;
   assign bus.pix_x       = x_q;
   assign bus.pix_y       = y_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         w_q     <= '0;
         h_q     <= '0;
         max_q   <= '0;
         iter_q  <= '0;
         cr0_q   <= '0;
         dcr_q   <= '0;
         dci_q   <= '0;
         cr_q    <= '0;
         ci_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         x_q     <= x_d;
         y_q     <= y_d;
         w_q     <= w_d;
         h_q     <= h_d;
         max_q   <= max_d;
         iter_q  <= iter_d;
         cr0_q   <= cr0_d;
         dcr_q   <= dcr_d;
         dci_q   <= dci_d;
         cr_q    <= cr_d;
         ci_q    <= ci_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      x_d     = x_q;
      y_d     = y_q;
      w_d     = w_q;
      h_d     = h_q;
      max_d   = max_q;
      iter_d  = iter_q;
      cr0_d   = cr0_q;
      dcr_d   = dcr_q;
      dci_d   = dci_q;
      cr_d    = cr_q;
      ci_d    = ci_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               if (width == '0 || height == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_LOAD;
                  k_d     = '0;
                  x_d     = '0;
                  y_d     = '0;
                  w_d     = width;
                  h_d     = height;
                  max_d   = max_iter;
                  cr0_d   = cr0;
                  dcr_d   = dcr;
                  dci_d   = dci;
                  cr_d    = cr0;
                  ci_d    = ci0;
               end
            end
         end
         S_LOAD: begin
            k_d = k_q + K_W'(1);
            if (load_last) state_d = S_ITER;
         end
         S_ITER: begin
            if (cnt_done) begin
               iter_d  = cnt_res;
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (xfer) begin
               state_d = S_LOAD;
               k_d     = '0;
               unique case (1'b1)
                  !last_x: begin
                     x_d  = x_q + COORD_W'(1);
                     cr_d = cr_q + dcr_q;
                  end
                  last_x && !last_y: begin
                     x_d  = '0;
                     cr_d = cr0_q;
                     y_d  = y_q + COORD_W'(1);
                     ci_d = ci_q + dci_q;
                  end
                  default: begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mandel_pixel_sequencer.sv
// Bench for mandel_pixel_sequencer: accelerator stub, per-cycle LOAD
// byte checks and a pixel scoreboard driven from a table of frames.
module tb_mandel_pixel_sequencer;

   typedef struct {
      logic [31:0] cr0, ci0, dcr, dci;
      logic [7:0]  w, h, mi;
      int          n;
      logic [7:0]  exp_it;
   } vec_t;

   typedef struct {
      logic [7:0]  x, y, it;
      logic [31:0] cr, ci;
      bit          last;
   } px_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0;
   logic [31:0] cr0 = '0, ci0 = '0, dcr = '0, dci = '0;
   logic [7:0]  width = '0, height = '0, max_iter = '0;
   logic        busy, frame_done;

   mandel_pixel_sequencer_if #(.MAX_ITER_W(8)) bus ();

   mandel_pixel_sequencer #(.MAX_ITER_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .cr0         (cr0),
      .ci0         (ci0),
      .dcr         (dcr),
      .dci         (dci),
      .width       (width),
      .height      (height),
      .max_iter    (max_iter),
      .busy        (busy),
      .frame_done  (frame_done),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int  n_chk = 0, n_pass = 0;
   int  done_cnt = 0, stray = 0;
   int  ld_k = -1;
   int  stub_n = -1;
   int  ev = -100;
   px_t sb[$];
   vec_t vecs[6];

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, a, e);
   endtask

   function automatic logic [37:0] outs();
      return {busy, frame_done, bus.acc_data, bus.acc_load_cr,
              bus.acc_load_ci, bus.acc_start, bus.pix_valid,
              bus.pix_iter, bus.pix_x, bus.pix_y};
   endfunction

   // Accelerator stub: flag is high during evaluation number stub_n.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ev <= -100;
         bus.acc_unbounded <= 1'b0;
      end else if (bus.acc_start) begin
         ev <= -1;
         bus.acc_unbounded <= 1'b0;
      end else begin
         ev <= ev + 1;
         bus.acc_unbounded <= (stub_n >= 0) && (ev + 1 == stub_n);
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         ld_k = -1;
      end else begin
         if (ld_k >= 0) begin
            if (sb.size() == 0) begin
               chk("load_no_pixel", 1, 0);
            end else begin
               logic [63:0] c;
               c = {sb[0].ci, sb[0].cr};
               chk("acc_data", bus.acc_data, c[ld_k*8 +: 8]);
               chk("strobes", {bus.acc_load_cr, bus.acc_load_ci, bus.acc_start},
                   {ld_k == 3, ld_k == 7, ld_k == 7});
            end
            ld_k = (ld_k == 7) ? -1 : ld_k + 1;
         end else if (bus.acc_load_cr || bus.acc_load_ci || bus.acc_start ||
                      bus.acc_data != 8'h00) begin
            stray++;
         end
         if (bus.pix_valid && bus.pix_ready) begin
            if (sb.size() == 0) begin
               chk("pix_unexpected", 1, 0);
            end else begin
               px_t e;
               e = sb.pop_front();
               chk("pix_x", bus.pix_x, e.x);
               chk("pix_y", bus.pix_y, e.y);
               chk("pix_iter", bus.pix_iter, e.it);
               if (!e.last) ld_k = 0;
            end
         end
         if (frame_start && !busy && width != 0 && height != 0) ld_k = 0;
         if (frame_done) done_cnt++;
      end
   end

   task automatic start_frame(input vec_t v);
      cr0 = v.cr0; ci0 = v.ci0; dcr = v.dcr; dci = v.dci;
      width = v.w; height = v.h; max_iter = v.mi; stub_n = v.n;
      for (int y = 0; y < int'(v.h); y++)
         for (int x = 0; x < int'(v.w); x++) begin
            px_t p;
            p.x = 8'(x); p.y = 8'(y); p.it = v.exp_it;
            p.cr = 32'(v.cr0 + 32'(x) * v.dcr);
            p.ci = 32'(v.ci0 + 32'(y) * v.dci);
            p.last = (x == int'(v.w) - 1) && (y == int'(v.h) - 1);
            sb.push_back(p);
         end
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
   endtask

   task automatic finish_frame(input int d0, input int s0);
      for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge clk);
      if (done_cnt == d0) chk("frame_timeout", 0, 1);
      repeat (3) @(negedge clk);
      chk("frame_done_cycles", done_cnt - d0, 1);
      chk("sb_empty", sb.size(), 0);
      chk("stray_strobes", stray - s0, 0);
      chk("idle_busy", busy, 0);
   endtask

   task automatic run_frame(input vec_t v);
      int d0, s0;
      d0 = done_cnt; s0 = stray;
      start_frame(v);
      finish_frame(d0, s0);
   endtask

   initial begin
      vec_t v;
      logic [23:0] snap;
      int d0, s0;
      vecs[0] = '{32'h10000000, 32'hF0000000, 32'h0, 32'h0, 8'd1, 8'd1, 8'd255, 5, 8'd5};
      vecs[1] = '{32'hF8000000, 32'h08000000, 32'h01000000, 32'h01000000, 8'd3, 8'd2, 8'd4, -1, 8'd4};
      vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 8'd1, 8'd1, 8'd0, -1, 8'd0};
      vecs[3] = '{32'h7F000000, 32'h7FFFFFFF, 32'h01000000, 32'h00000001, 8'd2, 8'd2, 8'd3, 2, 8'd2};
      vecs[4] = '{32'h00000000, 32'h00000000, 32'h00100000, 32'hFFF00000, 8'd2, 8'd1, 8'd3, 3, 8'd3};
      vecs[5] = '{32'hC0000000, 32'h40000000, 32'h0, 32'h0, 8'd1, 8'd1, 8'd7, 0, 8'd0};
      bus.pix_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1 chk("reset_outs", outs(), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("idle_outs", outs(), 0);

      for (int i = 0; i < 6; i++) run_frame(vecs[i]);

      // Backpressure, config changes and a stray frame_start mid-frame.
      v = '{32'h20000000, 32'h01000000, 32'hFF000000, 32'h0, 8'd2, 8'd1, 8'd6, 2, 8'd2};
      bus.pix_ready = 1'b0;
      d0 = done_cnt; s0 = stray;
      start_frame(v);
      chk("busy_in_frame", busy, 1);
      cr0 = 32'h0; ci0 = 32'h55555555; width = 8'd9; height = 8'd9;
      frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
      for (int i = 0; i < 300 && !bus.pix_valid; i++) @(negedge clk);
      chk("valid_seen", bus.pix_valid, 1);
      snap = {bus.pix_iter, bus.pix_x, bus.pix_y};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("out_hold", {bus.pix_valid, bus.pix_iter, bus.pix_x, bus.pix_y}, {1'b1, snap});
      end
      chk("hold_no_strobes", stray - s0, 0);
      @(posedge clk); #1 bus.pix_ready = 1'b1;
      finish_frame(d0, s0);

      // Zero-sized frames.
      v = '{32'h1, 32'h2, 32'h0, 32'h0, 8'd0, 8'd4, 8'd9, -1, 8'd0};
      for (int z = 0; z < 2; z++) begin
         if (z == 1) begin v.w = 8'd4; v.h = 8'd0; end
         d0 = done_cnt;
         start_frame(v);
         chk("zero_done", {frame_done, busy}, 2'b10);
         @(posedge clk); #1;
         chk("zero_done_pulse", frame_done, 0);
         repeat (6) @(negedge clk);
         chk("zero_done_cnt", done_cnt - d0, 1);
         chk("zero_no_valid", bus.pix_valid, 0);
      end

      // Reset during ITER of the second pixel.
      v = '{32'h01000000, 32'h02000000, 32'h00400000, 32'h00400000, 8'd3, 8'd2, 8'd20, -1, 8'd20};
      d0 = done_cnt;
      start_frame(v);
      for (int i = 0; i < 400 && sb.size() > 5; i++) @(negedge clk);
      chk("first_pixel_seen", sb.size(), 5);
      repeat (13) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk("midframe_reset_outs", outs(), 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("no_done_after_reset", done_cnt - d0, 0);
      chk("idle_after_reset", outs(), 0);
      run_frame(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
